// File: rtl/bus_utils.sv
`default_nettype none
// ============================================================================
//  Module      : bus_utils (package)
//  Description : Shared bus types and default sizing for the bus master path.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_utils;

    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_LEN_W  = 4;
    localparam int c_DEF_TO_CYC = 16;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_REQ  = 5'b00010,
        ST_ADDR = 5'b00100,
        ST_DATA = 5'b01000,
        ST_TURN = 5'b10000
    } mst_states_t;

endpackage
`default_nettype wire

// File: rtl/bus_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_beat_counter
//  Description : Burst beat counter and target wait-state timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_beat_counter
    import bus_utils::*;
#(
    parameter int LEN_W  = c_DEF_LEN_W,
    parameter int TO_CYC = c_DEF_TO_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_beat,
    input  logic             i_stall,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_last_beat,
    output logic             o_timeout
);

    localparam int c_WAIT_W = $clog2(TO_CYC + 1);

    // One extra bit so a full 2**LEN_W beat burst never wraps.
    logic [LEN_W:0]    r_beat_q;
    logic [c_WAIT_W-1:0] r_wait_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_q <= '0;
            r_wait_q <= '0;
        end else if (i_clear) begin
            r_beat_q <= '0;
            r_wait_q <= '0;
        end else if (i_beat) begin
            r_beat_q <= r_beat_q + (LEN_W + 1)'(1);
            r_wait_q <= '0;
        end else if (i_stall) begin
            r_wait_q <= r_wait_q + c_WAIT_W'(1);
        end
    end

    assign o_last_beat = (r_beat_q == {1'b0, i_len});
    assign o_timeout   = i_stall && (r_wait_q == c_WAIT_W'(TO_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_master_if
//  Description : Initiator-side write-burst interface: request/grant, address
//                and data phases with target wait-state timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_master_if
    import bus_utils::*;
#(
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int LEN_W  = c_DEF_LEN_W,
    parameter int TO_CYC = c_DEF_TO_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic              req_n,
    input  logic              gnt_n,
    output logic              frame_n,
    output logic              irdy_n,
    input  logic              trdy_n,
    output logic [DATA_W-1:0] ad,
    output logic              done,
    output logic              abort
);

    mst_states_t       r_state;
    mst_states_t       w_next;
    logic [DATA_W-1:0] r_addr_q;
    logic [LEN_W-1:0]  r_len_q;
    logic              r_done;
    logic              r_abort;

    logic w_in_data;
    logic w_beat;
    logic w_stall;
    logic w_last;
    logic w_timeout;

    assign w_in_data = (r_state == ST_DATA);
    assign w_beat    = w_in_data && wdata_valid && !trdy_n;
    // Only target-side waits count; a client with no data does not age the timer.
    assign w_stall   = w_in_data && wdata_valid && trdy_n;

    bus_beat_counter #(
        .LEN_W  (LEN_W),
        .TO_CYC (TO_CYC)
    ) u_beat_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (r_state == ST_IDLE),
        .i_beat      (w_beat),
        .i_stall     (w_stall),
        .i_len       (r_len_q),
        .o_last_beat (w_last),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_addr_q <= '0;
            r_len_q  <= '0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_beat && w_last;
            r_abort <= w_timeout;
            if (r_state == ST_IDLE && cmd_valid) begin
                r_addr_q <= cmd_addr;
                r_len_q  <= cmd_len;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        req_n     = 1'b1;
        frame_n   = 1'b1;
        irdy_n    = 1'b1;
        ad        = '0;
        unique case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = ST_REQ;
            end
            ST_REQ: begin
                req_n = 1'b0;
                if (!gnt_n) w_next = ST_ADDR;
            end
            ST_ADDR: begin
                frame_n = 1'b0;
                ad      = r_addr_q;
                w_next  = ST_DATA;
            end
            ST_DATA: begin
                frame_n = w_last;
                irdy_n  = !wdata_valid;
                ad      = wdata;
                if ((w_beat && w_last) || w_timeout) w_next = ST_TURN;
            end
            ST_TURN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign wdata_ready = w_beat;
    assign done        = r_done;
    assign abort       = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bus_master_if
//  Description : Randomized self-checking bench for bus_master_if with a
//                behavioural client/target/arbiter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master_if;

    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        req_n;
    logic        gnt_n;
    logic        frame_n;
    logic        irdy_n;
    logic        trdy_n;
    logic [31:0] ad;
    logic        done;
    logic        abort;

    int errors = 0;
    int checks = 0;

    int          waits [16];
    int          stall_beat;
    int          stall_cycles;
    logic [31:0] next_addr;
    logic [3:0]  next_len;

    always #5 clk = ~clk;

    bus_master_if #(
        .DATA_W (32),
        .LEN_W  (4),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .req_n       (req_n),
        .gnt_n       (gnt_n),
        .frame_n     (frame_n),
        .irdy_n      (irdy_n),
        .trdy_n      (trdy_n),
        .ad          (ad),
        .done        (done),
        .abort       (abort)
    );

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) waits[i] = 0;
        stall_beat   = -1;
        stall_cycles = 0;
    endtask

    // One complete burst as seen by client, arbiter and target.
    // waits[b]: target wait cycles (while irdy low) before accepting beat b.
    task automatic run_burst(input logic [31:0] a, input int len, input int gdly,
                             input bit keep, input int rst_beat);
        int          beat;
        int          wleft;
        int          stall_left;
        int          consec;
        bit          fin_done;
        bit          fin_abort;
        bit          offered_prev;
        bit          exp_beat;
        logic [31:0] cur;
        logic [5:0]  exp_v;

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = 4'(len);
        @(negedge clk);
        checks++;
        if ({cmd_ready, req_n, frame_n, done, abort} !== 5'b11100) begin
            errors++;
            $display("FAIL idle_ready: got rdy/req_n/frame_n/done/abort=%b want 11100",
                     {cmd_ready, req_n, frame_n, done, abort});
        end

        @(posedge clk); #1;
        if (keep) begin
            cmd_addr = next_addr; cmd_len = next_len;
        end else begin
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 4'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({req_n, cmd_ready} !== 2'b00) begin
            errors++;
            $display("FAIL req_assert: got req_n/cmd_ready=%b want 00", {req_n, cmd_ready});
        end
        repeat (gdly) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({req_n, frame_n} !== 2'b01) begin
                errors++;
                $display("FAIL req_wait: got req_n/frame_n=%b want 01", {req_n, frame_n});
            end
        end

        @(posedge clk); #1;
        gnt_n        = 1'b0;
        beat         = 0;
        consec       = 0;
        fin_done     = 1'b0;
        fin_abort    = 1'b0;
        offered_prev = 1'b0;
        cur          = $urandom;
        wleft        = waits[0];
        stall_left   = (stall_beat == 0) ? stall_cycles : 0;
        @(negedge clk);

        // Address phase: trdy_n and wdata_valid must be ignored here.
        @(posedge clk); #1;
        trdy_n = 1'($urandom); wdata_valid = 1'b1; wdata = cur;
        @(negedge clk);
        checks++;
        if ({frame_n, irdy_n, req_n, wdata_ready} !== 4'b0110 || ad !== a) begin
            errors++;
            $display("FAIL addr_phase: got frame/irdy/req/wrdy=%b ad=%h want 0110 ad=%h",
                     {frame_n, irdy_n, req_n, wdata_ready}, ad, a);
        end

        for (int cyc = 0; cyc < 400 && !fin_done && !fin_abort; cyc++) begin
            @(posedge clk); #1;
            gnt_n       = 1'($urandom);
            wdata_valid = (stall_left == 0);
            assert (!(offered_prev && !wdata_valid))
                else $error("client dropped wdata_valid mid-handshake");
            wdata  = wdata_valid ? cur : $urandom;
            trdy_n = (wleft > 0);
            @(negedge clk);
            exp_beat = wdata_valid && !trdy_n;
            exp_v = {logic'(beat == len), !wdata_valid, exp_beat, 1'b1, 1'b0, 1'b0};
            checks++;
            if ({frame_n, irdy_n, wdata_ready, req_n, done, abort} !== exp_v || ad !== wdata) begin
                errors++;
                $display("FAIL data_phase b%0d: got frame/irdy/wrdy/req/done/abort=%b ad=%h want %b ad=%h",
                         beat, {frame_n, irdy_n, wdata_ready, req_n, done, abort}, ad, exp_v, wdata);
            end

            if (rst_beat >= 0 && beat == rst_beat) begin
                #3; reset = 1'b0; #1;
                checks++;
                if ({frame_n, irdy_n, req_n, wdata_ready} !== 4'b1110 || ad !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_async: got frame/irdy/req/wrdy=%b ad=%h want 1110 ad=0",
                             {frame_n, irdy_n, req_n, wdata_ready}, ad);
                end
                cmd_valid = 1'b0; trdy_n = 1'b1; wdata_valid = 1'b0; gnt_n = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                #3; reset = 1'b1;
                @(negedge clk);
                checks++;
                if ({cmd_ready, req_n, frame_n, done, abort} !== 5'b11100) begin
                    errors++;
                    $display("FAIL reset_release: got rdy/req/frame/done/abort=%b want 11100",
                             {cmd_ready, req_n, frame_n, done, abort});
                end
                return;
            end

            if (exp_beat) begin
                beat++;
                consec       = 0;
                offered_prev = 1'b0;
                if (beat == len + 1) begin
                    fin_done = 1'b1;
                end else begin
                    cur        = $urandom;
                    wleft      = waits[beat];
                    stall_left = (stall_beat == beat) ? stall_cycles : 0;
                end
            end else if (wdata_valid) begin
                offered_prev = 1'b1;
                consec++;
                if (wleft > 0) wleft--;
                if (consec == TO_CYC) fin_abort = 1'b1;
            end else begin
                stall_left--;
            end
        end

        if (!fin_done && !fin_abort) begin
            errors++;
            $display("FAIL burst_bound: burst did not end within 400 cycles");
        end

        @(posedge clk); #1;
        trdy_n = 1'b1; wdata_valid = 1'b0; gnt_n = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 1'b0, 1'b1, fin_done, fin_abort};
        checks++;
        if ({frame_n, irdy_n, wdata_ready, req_n, done, abort} !== exp_v
            || ad !== 32'h0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL turn_phase: got frame/irdy/wrdy/req/done/abort=%b ad=%h rdy=%b want %b ad=0 rdy=0",
                     {frame_n, irdy_n, wdata_ready, req_n, done, abort}, ad, cmd_ready, exp_v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata = '0; wdata_valid = 1'b0; gnt_n = 1'b1; trdy_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, req_n, frame_n, irdy_n, done, abort, wdata_ready} !== 7'b1111000
            || ad !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got %b ad=%h want 1111000 ad=0",
                     {cmd_ready, req_n, frame_n, irdy_n, done, abort, wdata_ready}, ad);
        end
        #3; reset = 1'b1;
    endtask

    task automatic test_idle_gnt();
        @(posedge clk); #1; gnt_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, req_n, frame_n, irdy_n} !== 4'b1111) begin
            errors++;
            $display("FAIL idle_gnt: got rdy/req/frame/irdy=%b want 1111",
                     {cmd_ready, req_n, frame_n, irdy_n});
        end
        @(posedge clk); #1; gnt_n = 1'b1;
    endtask

    task automatic test_single();
        clear_plan();
        run_burst(32'h0000_0100, 0, 2, 1'b0, -1);
    endtask

    task automatic test_burst4();
        clear_plan();
        waits[1] = 2;
        run_burst(32'hA000_0040, 3, 1, 1'b0, -1);
    endtask

    task automatic test_timeout();
        clear_plan();
        waits[0] = 1000;
        run_burst(32'h0000_2000, 3, 0, 1'b0, -1);
        clear_plan();
        waits[2] = 1000;
        run_burst(32'h0000_3000, 5, 1, 1'b0, -1);
    endtask

    task automatic test_wait_boundary();
        clear_plan();
        waits[0] = TO_CYC - 1;
        run_burst(32'h0000_4000, 0, 0, 1'b0, -1);
        clear_plan();
        waits[1] = TO_CYC;
        run_burst(32'h0000_5000, 1, 0, 1'b0, -1);
    endtask

    task automatic test_client_stall();
        clear_plan();
        stall_beat = 1; stall_cycles = 20; waits[1] = 10;
        run_burst(32'h0000_6000, 3, 2, 1'b0, -1);
    endtask

    task automatic test_max_len();
        clear_plan();
        for (int i = 0; i < 16; i++) waits[i] = int'($urandom_range(0, 3));
        run_burst(32'hFFFF_FFF0, 15, 1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            clear_plan();
            for (int i = 0; i < 16; i++) waits[i] = int'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) begin
                stall_beat   = int'($urandom_range(0, 3));
                stall_cycles = int'($urandom_range(1, 25));
            end
            if ($urandom_range(0, 4) == 0) waits[$urandom_range(0, 3)] = 1000;
            run_burst($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid();
        clear_plan();
        run_burst(32'h0000_7000, 3, 0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        clear_plan();
        next_addr = 32'hBEEF_0000; next_len = 4'd2;
        waits[0] = 1;
        run_burst(32'hCAFE_0000, 1, 0, 1'b1, -1);
        clear_plan();
        run_burst(next_addr, int'(next_len), 1, 1'b0, -1);
    endtask

    initial begin
        stall_beat   = -1;
        stall_cycles = 0;
        next_addr    = '0;
        next_len     = '0;
        test_reset();
        test_idle_gnt();
        test_single();
        test_burst4();
        test_timeout();
        test_wait_boundary();
        test_client_stall();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
